// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: shift pattern in, one capture clock, shift response out, compare.
// Optional sticky failure flag enabled by defining SCAN_TEST_CTRL_STICKY_FAIL_EN.
module scan_test_ctrl #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 scan_out,
    output logic                 scan_in,
    output logic                 scan_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
    output logic [CHAIN_LEN-1:0] response,
    output logic                 fail_sticky
`else
    output logic [CHAIN_LEN-1:0] response
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_CAPTURE   = 3'd2,
        S_SHIFT_OUT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_d;
    logic                 start_acc_c;

    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] pat_d;
    logic [CHAIN_LEN-1:0] exp_d;
    logic [CHAIN_LEN-1:0] pat_shift;
    logic [CHAIN_LEN-1:0] response_d;
    logic                 scan_in_d;
    logic                 scan_en_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 pass_d;
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
    logic                 fail_sticky_d;
`endif

    assign start_acc_c = (state == S_IDLE) && start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and bit counter
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT_IN;
                    cnt_d   = '0;
                end
            end
            S_SHIFT_IN: begin
                if (cnt == CNT_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                state_d = S_SHIFT_OUT;
                cnt_d   = '0;
            end
            S_SHIFT_OUT: begin
                if (cnt == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        pat_d      = pat_q;
        exp_d      = exp_q;
        pat_shift  = '0;
        response_d = response;
        scan_in_d  = 1'b0;
        scan_en_d  = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pass_d     = pass;
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
        fail_sticky_d = fail_sticky;
`endif

        if (start_acc_c) begin
            pat_d  = pattern;
            exp_d  = expected;
            pass_d = 1'b0;
        end

        if (state == S_SHIFT_OUT) begin
            response_d = {response[CHAIN_LEN-2:0], scan_out};
        end

        case (state_d)
            S_SHIFT_IN: begin
                // MSB first so that flop i ends up holding pattern bit i
                pat_shift = pat_d << cnt_d;
                scan_in_d = pat_shift[CHAIN_LEN-1];
                busy_d    = 1'b1;
            end
            S_CAPTURE: begin
                scan_en_d = 1'b0;
                busy_d    = 1'b1;
            end
            S_SHIFT_OUT: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                pass_d = (response_d == exp_q);
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase

`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
        // All-ones pattern and expected on an accepted start clears the flag
        if (start_acc_c && (&pattern) && (&expected)) begin
            fail_sticky_d = 1'b0;
        end
        if ((state_d == S_DONE) && !pass_d) begin
            fail_sticky_d = 1'b1;
        end
`endif
    end

    // Output and operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q    <= '0;
            exp_q    <= '0;
            response <= '0;
            scan_in  <= 1'b0;
            scan_en  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
            fail_sticky <= 1'b0;
`endif
        end else begin
            pat_q    <= pat_d;
            exp_q    <= exp_d;
            response <= response_d;
            scan_in  <= scan_in_d;
            scan_en  <= scan_en_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
            fail_sticky <= fail_sticky_d;
`endif
        end
    end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Self-checking bench for scan_test_ctrl with a behavioural 8-flop scan chain.
module tb_scan_test_ctrl;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] pattern;
    logic [N-1:0] expected;
    logic         scan_out;
    logic         scan_in;
    logic         scan_en;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N-1:0] response;
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
    logic         fail_sticky;
    bit           sticky_ref = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Chain mode: 0 = capture inverts contents, 1 = 4x4 multiplier (a = flops 3:0, b = flops 7:4)
    bit           mode = 1'b0;
    logic [N-1:0] chain = '0;

    always #5 clk = ~clk;

    scan_test_ctrl #(.CHAIN_LEN(N), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .expected (expected),
        .scan_out (scan_out),
        .scan_in  (scan_in),
        .scan_en  (scan_en),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
        .response (response),
        .fail_sticky (fail_sticky)
`else
        .response (response)
`endif
    );

    assign scan_out = chain[N-1];

    always_ff @(posedge clk) begin
        if (scan_en) chain <= {chain[N-2:0], scan_in};
        else if (mode) chain <= {4'b0, chain[3:0]} * {4'b0, chain[7:4]};
        else chain <= ~chain;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] ref_resp(input logic [N-1:0] p, input bit mul);
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = {4'b0, p[3:0]};
        b = {4'b0, p[7:4]};
        return mul ? N'(a * b) : ~p;
    endfunction

    // One complete run, checking every cycle from accept to the cycle after done
    task automatic run_one(input logic [N-1:0] p, input logic [N-1:0] e, input bit mul);
        logic [N-1:0] r;
        r    = ref_resp(p, mul);
        mode = mul;
        @(negedge clk);
        start = 1'b1; pattern = p; expected = e;
        @(posedge clk);
        #1 start = 1'b0;
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
        if ((&p) && (&e)) sticky_ref = 1'b0;
        check("sticky_at_start", 32'(fail_sticky), 32'(sticky_ref));
`endif
        for (int k = 1; k <= 2 * N + 1; k++) begin
            @(negedge clk);
            pattern  = N'($urandom);
            expected = N'($urandom);
            check("scan_en", 32'(scan_en), (k == N + 1) ? 32'd0 : 32'd1);
            if (k <= N) check("scan_in", 32'(scan_in), 32'(p[N-k]));
            check("busy_run", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("response", 32'(response), 32'(r));
        check("pass", 32'(pass), 32'(r == e));
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
        if (r != e) sticky_ref = 1'b1;
        check("sticky_done", 32'(fail_sticky), 32'(sticky_ref));
`endif
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("pass_hold", 32'(pass), 32'(r == e));
    endtask

    initial begin
        logic [N-1:0] p;
        logic [N-1:0] e;
        bit           mul;
        bit           saw_done;

        rst = 1'b1; start = 1'b0; pattern = '0; expected = '0;
        #1;
        check("rst_scan_en", 32'(scan_en), 32'd1);
        check("rst_scan_in", 32'(scan_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_response", 32'(response), 32'd0);
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
        check("rst_sticky", 32'(fail_sticky), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_one(8'hA5, 8'h5A, 1'b0);
        run_one(8'h0F, 8'h00, 1'b0);
        run_one(8'h00, 8'h00, 1'b1);
        run_one(8'hA5, 8'h5A, 1'b0);
        run_one(8'hFF, 8'hFF, 1'b0);
        run_one(8'h3B, 8'h21, 1'b1);

        // Start held high: only edges T and T+19 may begin runs
        mode = 1'b0;
        @(negedge clk);
        start = 1'b1; pattern = 8'h96; expected = 8'h69;
        @(posedge clk);
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            check("hold_busy", 32'(busy), (k == 18 || k == 19 || k == 37) ? 32'd0 : 32'd1);
            check("hold_done", 32'(done), (k == 18 || k == 37) ? 32'd1 : 32'd0);
            if (k == 37) start = 1'b0;
        end
        @(negedge clk);
        check("hold_idle", 32'(busy), 32'd0);

        // Reset during SHIFT_OUT
        @(negedge clk);
        start = 1'b1; pattern = 8'hA5; expected = 8'h5A;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_scan_en", 32'(scan_en), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pass", 32'(pass), 32'd0);
        check("mid_rst_response", 32'(response), 32'd0);
`ifdef SCAN_TEST_CTRL_STICKY_FAIL_EN
        sticky_ref = 1'b0;
        check("mid_rst_sticky", 32'(fail_sticky), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("mid_rst_quiet", 32'(saw_done), 32'd0);
        check("mid_rst_pass_after", 32'(pass), 32'd0);
        run_one(8'hA5, 8'h5A, 1'b0);

        // Randomized runs, half of them with a matching golden vector
        for (int i = 0; i < 20; i++) begin
            p   = N'($urandom);
            mul = 1'($urandom);
            e   = ($urandom_range(1, 0) == 1) ? ref_resp(p, mul) : N'($urandom);
            run_one(p, e, mul);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
